// File: rtl/multi_digit_clock.sv
// BCD HH:MM:SS time-of-day with run/set FSM, scanned onto a multiplexed
// 7-segment display of 4 or 6 digits with blinking colon and field blanking.
module multi_digit_clock #(
  parameter int CLK_HZ         = 25_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_en,
  input  logic                  disp_mode,
  input  logic                  set_pulse,
  input  logic                  inc_pulse,
  output logic [NUM_DIGITS-1:0] sel_digit,
  output logic [7:0]            sel_seg,
  output logic                  sec_tick,
  output logic [23:0]           time_bcd
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = $clog2(CLK_HZ);
  localparam int DW_W  = $clog2(DWELL);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);
  localparam logic [DW_W-1:0]  DW_MAX   = DW_W'(DWELL - 1);
  localparam logic [2:0]       IDX_MAX  = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_HR  = 2'd1;
  localparam logic [1:0] ST_MIN = 2'd2;

  // Two-digit BCD increment wrapping from 'top' to 00; never leaves BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [7:0]            hh, mm, ss;
  logic [PRE_W-1:0]      pre, pre_inc;
  logic [1:0]            state;
  logic [DW_W-1:0]       dwell;
  logic [2:0]            idx;
  logic                  mode_q;
  logic                  mode_eff;
  logic [2:0]            pos;
  logic [3:0]            nib;
  logic                  first_half, blank, dp;
  logic [7:0]            seg_raw, seg_nxt;
  logic [NUM_DIGITS-1:0] dig_raw, dig_nxt;

  assign time_bcd = {hh, mm, ss};
  assign pre_inc  = (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);

  // Display mode is sampled only on the first cycle of each dwell.
  always_comb begin
    mode_eff = (dwell == '0) ? disp_mode : mode_q;
    pos = idx + ((NUM_DIGITS == 4 && mode_eff) ? 3'd2 : 3'd0);
    case (pos)
      3'd0:    nib = ss[3:0];
      3'd1:    nib = ss[7:4];
      3'd2:    nib = mm[3:0];
      3'd3:    nib = mm[7:4];
      3'd4:    nib = hh[3:0];
      default: nib = hh[7:4];
    endcase
    first_half = pre < PRE_HALF;
    blank = !first_half && ((state == ST_HR && pos >= 3'd4) ||
                            (state == ST_MIN && pos[2:1] == 2'b01));
    dp = (idx == 3'd2 || (NUM_DIGITS == 6 && idx == 3'd4)) &&
         (state != ST_RUN || first_half);
    seg_raw = {dp, blank ? 7'h00 : seg7(nib)};
    dig_raw = NUM_DIGITS'(1) << idx;
    seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dig_nxt = (DIG_ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hh        <= 8'h00;
      mm        <= 8'h00;
      ss        <= 8'h00;
      pre       <= '0;
      state     <= ST_RUN;
      dwell     <= '0;
      idx       <= 3'd0;
      mode_q    <= 1'b0;
      sec_tick  <= 1'b0;
      sel_digit <= DIG_OFF;
      sel_seg   <= SEG_OFF;
    end else begin
      sel_digit <= dig_nxt;
      sel_seg   <= seg_nxt;
      sec_tick  <= 1'b0;
      mode_q    <= mode_eff;
      if (dwell == DW_MAX) begin
        dwell <= '0;
        idx   <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
      end else begin
        dwell <= dwell + DW_W'(1);
      end
      // set_pulse takes priority; a coincident inc_pulse is dropped.
      if (set_pulse) begin
        case (state)
          ST_RUN: begin
            state <= ST_HR;
            ss    <= 8'h00;
            pre   <= '0;
          end
          ST_HR: begin
            state <= ST_MIN;
            pre   <= pre_inc;
          end
          default: begin
            state <= ST_RUN;
            pre   <= '0;
          end
        endcase
      end else if (state != ST_RUN) begin
        pre <= pre_inc;
        if (inc_pulse && state == ST_HR)  hh <= bcd_inc(hh, 8'h23);
        if (inc_pulse && state == ST_MIN) mm <= bcd_inc(mm, 8'h59);
      end else if (run_en) begin
        pre <= pre_inc;
        if (pre == PRE_MAX) begin
          sec_tick <= 1'b1;
          ss <= bcd_inc(ss, 8'h59);
          if (ss == 8'h59) begin
            mm <= bcd_inc(mm, 8'h59);
            if (mm == 8'h59) hh <= bcd_inc(hh, 8'h23);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_digit_clock.sv
// Bench for multi_digit_clock: 4- and 6-digit instances driven in parallel,
// directed sequences plus random stimulus against a seconds-of-day model.
module tb_multi_digit_clock;

  localparam int CLK_HZ = 20;
  localparam int SCAN_HZ = 5;
  localparam int DW = CLK_HZ / SCAN_HZ;
  localparam int HALF = CLK_HZ / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_en = 1'b0;
  logic disp_mode = 1'b0;
  logic set_pulse = 1'b0;
  logic inc_pulse = 1'b0;
  logic [3:0]  dig4;
  logic [5:0]  dig6;
  logic [7:0]  seg4, seg6;
  logic        tick4, tick6;
  logic [23:0] t4, t6;

  multi_digit_clock #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(4),
                      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u4 (
    .clk(clk), .rst(rst), .run_en(run_en), .disp_mode(disp_mode),
    .set_pulse(set_pulse), .inc_pulse(inc_pulse), .sel_digit(dig4),
    .sel_seg(seg4), .sec_tick(tick4), .time_bcd(t4));

  multi_digit_clock #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(6),
                      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u6 (
    .clk(clk), .rst(rst), .run_en(run_en), .disp_mode(disp_mode),
    .set_pulse(set_pulse), .inc_pulse(inc_pulse), .sel_digit(dig6),
    .sel_seg(seg6), .sec_tick(tick6), .time_bcd(t6));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: time as seconds of day, state 0=run 1=set hours 2=set minutes,
  // m_sc counts cycles since reset modulo a full 4- and 6-digit scan period.
  int   m_tod, m_st, m_pre, m_sc;
  bit   m_mode;
  logic e_tick;
  logic [3:0] e_dig4;
  logic [5:0] e_dig6;
  logic [7:0] e_seg4, e_seg6;
  logic [6:0] pat [10];

  typedef struct {
    bit          set;
    bit          inc;
    int          reps;
    logic [23:0] exp_time;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] tod_bcd(input int t);
    int h = t / 3600;
    int m = (t / 60) % 60;
    int s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] exp_seg(input int n, input int idx, input bit mode);
    int h = m_tod / 3600;
    int m = (m_tod / 60) % 60;
    int s = m_tod % 60;
    int dg [6];
    int pos;
    bit blank, dp;
    logic [7:0] v;
    dg = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    pos = idx + ((n == 4 && mode) ? 2 : 0);
    blank = ((m_st == 1 && pos / 2 == 2) || (m_st == 2 && pos / 2 == 1)) && m_pre >= HALF;
    dp = (idx == 2 || (n == 6 && idx == 4)) && (m_st != 0 || m_pre < HALF);
    v = {dp, blank ? 7'h00 : pat[dg[pos]]};
    return ~v;
  endfunction

  task automatic model_edge();
    int i4, i6;
    if (rst) begin
      m_tod = 0; m_st = 0; m_pre = 0; m_sc = 0; m_mode = 0; e_tick = 0;
      e_dig4 = 4'hF; e_dig6 = 6'h3F; e_seg4 = 8'hFF; e_seg6 = 8'hFF;
      return;
    end
    if (m_sc % DW == 0) m_mode = disp_mode;
    i4 = (m_sc / DW) % 4;
    i6 = (m_sc / DW) % 6;
    e_dig4 = ~(4'b1 << i4);
    e_dig6 = ~(6'b1 << i6);
    e_seg4 = exp_seg(4, i4, m_mode);
    e_seg6 = exp_seg(6, i6, m_mode);
    m_sc = (m_sc + 1) % (DW * 12);
    e_tick = 0;
    if (set_pulse) begin
      if (m_st == 0) begin m_st = 1; m_tod -= m_tod % 60; m_pre = 0; end
      else if (m_st == 1) begin m_st = 2; m_pre = (m_pre + 1) % CLK_HZ; end
      else begin m_st = 0; m_pre = 0; end
    end else if (m_st != 0) begin
      m_pre = (m_pre + 1) % CLK_HZ;
      if (inc_pulse) begin
        if (m_st == 1) m_tod = ((m_tod / 3600 + 1) % 24) * 3600 + m_tod % 3600;
        else m_tod = (m_tod / 3600) * 3600 + (((m_tod / 60) % 60 + 1) % 60) * 60 + m_tod % 60;
      end
    end else if (run_en) begin
      if (m_pre == CLK_HZ - 1) begin
        m_pre = 0; e_tick = 1; m_tod = (m_tod + 1) % 86400;
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("dig4", dig4, e_dig4);
    chk("seg4", seg4, e_seg4);
    chk("tick4", tick4, e_tick);
    chk("time4", t4, tod_bcd(m_tod));
    chk("dig6", dig6, e_dig6);
    chk("seg6", seg6, e_seg6);
    chk("tick6", tick6, e_tick);
    chk("time6", t6, tod_bcd(m_tod));
  endtask

  task automatic do_reset();
    rst = 1'b1; set_pulse = 1'b0; inc_pulse = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic pulses(input bit s, input bit i, input int n);
    for (int k = 0; k < n; k++) begin
      set_pulse = s; inc_pulse = i;
      step();
    end
    set_pulse = 1'b0; inc_pulse = 1'b0;
  endtask

  initial begin
    logic [3:0] walk4 [4];
    logic [5:0] walk6 [6];
    int ticks, lat, blank_n, lit_n;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    walk4 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    walk6 = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    tbl[0] = '{set: 1'b1, inc: 1'b0, reps: 1,  exp_time: 24'h000000};
    tbl[1] = '{set: 1'b0, inc: 1'b1, reps: 25, exp_time: 24'h010000};
    tbl[2] = '{set: 1'b1, inc: 1'b1, reps: 1,  exp_time: 24'h010000};
    tbl[3] = '{set: 1'b0, inc: 1'b1, reps: 61, exp_time: 24'h010100};
    tbl[4] = '{set: 1'b1, inc: 1'b0, reps: 1,  exp_time: 24'h010100};

    // Reset values, one second of run, digit walk for both widths
    do_reset();
    chk("rst_dig4", dig4, 4'hF);
    chk("rst_dig6", dig6, 6'h3F);
    chk("rst_seg4", seg4, 8'hFF);
    chk("rst_tick", tick4, 1'b0);
    chk("rst_time", t4, 24'h000000);
    run_en = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k <= 20 && tick4) ticks++;
      if ((k - 1) % 4 == 0) begin
        if ((k - 1) / 4 < 4) chk("walk4", dig4, walk4[(k - 1) / 4]);
        chk("walk6", dig6, walk6[(k - 1) / 4]);
      end
      if (k == 20) chk("t1_time", t4, 24'h000001);
    end
    chk("t1_ticks", ticks, 1);

    // Set FSM: seconds cleared, hour/minute wraps, set beats inc
    do_reset();
    run_en = 1'b1;
    repeat (40) step();
    chk("pre_set_time", t4, 24'h000002);
    foreach (tbl[i]) begin
      pulses(tbl[i].set, tbl[i].inc, tbl[i].reps);
      chk("tbl_time", t4, tbl[i].exp_time);
    end
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      if (tick4) lat = k;
    end
    chk("first_tick_lat", lat, 20);
    chk("after_set_time", t4, 24'h010101);
    pulses(1'b0, 1'b1, 3);
    chk("inc_in_run", t4, 24'h010101);
    disp_mode = 1'b1;
    repeat (32) step();
    disp_mode = 1'b0;

    // Preload 23:59:59, freeze, then midnight wrap
    do_reset();
    run_en = 1'b1;
    pulses(1'b1, 1'b0, 1);
    pulses(1'b0, 1'b1, 23);
    pulses(1'b1, 1'b0, 1);
    pulses(1'b0, 1'b1, 59);
    pulses(1'b1, 1'b0, 1);
    chk("preload", t4, 24'h235900);
    repeat (59 * CLK_HZ) step();
    chk("at_235959", t4, 24'h235959);
    run_en = 1'b0;
    ticks = 0;
    repeat (20) begin step(); if (tick4) ticks++; end
    chk("frozen_ticks", ticks, 0);
    chk("frozen_time", t4, 24'h235959);
    run_en = 1'b1;
    ticks = 0;
    repeat (20) begin step(); if (tick4) ticks++; end
    chk("wrap_ticks", ticks, 1);
    chk("wrap_time", t4, 24'h000000);

    // Minute field blinking in SET_MIN with colon steady on
    do_reset();
    run_en = 1'b1;
    pulses(1'b1, 1'b0, 2);
    blank_n = 0;
    lit_n = 0;
    repeat (40) begin
      step();
      if (dig4 == 4'b1011 || dig4 == 4'b0111) begin
        if (seg4[6:0] == 7'h7F) blank_n++;
        else if (seg4[6:0] == 7'h40) lit_n++;
      end
      if (dig4 == 4'b1011) chk("set_colon", seg4[7], 1'b0);
    end
    chk("blank_seen", blank_n > 0, 1'b1);
    chk("lit_seen", lit_n > 0, 1'b1);
    pulses(1'b1, 1'b0, 1);
    repeat (40) step();

    // Reset while in SET_MIN with scan on digit 2
    pulses(1'b1, 1'b0, 2);
    for (int k = 0; k < 20 && dig4 != 4'b1011; k++) step();
    chk("idx2_reach", dig4, 4'b1011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_dig4", dig4, 4'hF);
    chk("midrst_dig6", dig6, 6'h3F);
    chk("midrst_seg", seg4, 8'hFF);
    chk("midrst_time", t4, 24'h000000);
    repeat (24) step();

    // Random stimulus against the model
    for (int k = 0; k < 2500; k++) begin
      set_pulse = ($urandom_range(0, 39) == 0);
      inc_pulse = ($urandom_range(0, 5) == 0);
      run_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 30) == 0) disp_mode = ~disp_mode;
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0; set_pulse = 1'b0; inc_pulse = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
